// File: rtl/plab3_mem_line_responder.sv
// plab3_mem_line_responder: line-granularity backing memory; memreq_* val/rdy in (type,opaque,addr,len,data), memresp_* val/rdy out (type,opaque,len,data) after p_latency
module plab3_mem_line_responder #(
  parameter int p_mem_nbytes = 4096,
  parameter int p_opaque_nbits = 8,
  parameter int p_latency = 2,
  parameter int abw = 32,
  parameter int clw = 128,
  localparam int lw = $clog2(clw/8),
  localparam int req_nbits = 3 + p_opaque_nbits + abw + lw + clw,
  localparam int resp_nbits = 3 + p_opaque_nbits + lw + clw
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  domain,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  input  logic [req_nbits-1:0]  memreq_msg,
  output logic                  memresp_val,
  input  logic                  memresp_rdy,
  output logic [resp_nbits-1:0] memresp_msg
);
  localparam int nb = clw/8;
  localparam int ib = $clog2(p_mem_nbytes);
  localparam int nlines = p_mem_nbytes/nb;
  localparam logic [3:0] lat_m1 = 4'(p_latency > 0 ? p_latency - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] type_q, type_d, s_type;
  logic [p_opaque_nbits-1:0] opaque_q, opaque_d, s_opaque;
  logic [abw-1:0] addr_q, addr_d, s_addr;
  logic [lw-1:0] len_q, len_d, s_len;
  logic [clw-1:0] data_q, data_d, s_data, line, wline;
  logic [resp_nbits-1:0] resp_q, resp_d;
  logic [clw-1:0] mem [nlines];
  logic [ib-lw-1:0] idx;
  logic fire, enter, is_wr;
  int off, doff, n;
  logic unused_ok;
  assign unused_ok = ^{domain, s_addr[abw-1:ib]};
  assign memreq_rdy = ~reset & (state_q == IDLE);
  assign memresp_val = (state_q == RESP);
  assign memresp_msg = resp_q;
  always_comb begin
    fire = memreq_val & memreq_rdy;
    // with zero latency the store access happens on the accept edge, so use the live request
    s_type = (state_q == IDLE) ? memreq_msg[req_nbits-1 -: 3] : type_q;
    s_opaque = (state_q == IDLE) ? memreq_msg[req_nbits-4 -: p_opaque_nbits] : opaque_q;
    s_addr = (state_q == IDLE) ? memreq_msg[lw+clw +: abw] : addr_q;
    s_len = (state_q == IDLE) ? memreq_msg[clw +: lw] : len_q;
    s_data = (state_q == IDLE) ? memreq_msg[clw-1:0] : data_q;
    type_d = fire ? s_type : type_q;
    opaque_d = fire ? s_opaque : opaque_q;
    addr_d = fire ? s_addr : addr_q;
    len_d = fire ? s_len : len_q;
    data_d = fire ? s_data : data_q;
    enter = ~reset & ((fire & (p_latency == 0)) | ((state_q == WAIT) & (cnt_q == 4'd0)));
    state_d = (state_q == IDLE) ? (fire ? (p_latency == 0 ? RESP : WAIT) : IDLE) :
              (state_q == WAIT) ? (cnt_q == 4'd0 ? RESP : WAIT) :
              (memresp_rdy ? IDLE : RESP);
    cnt_d = fire ? lat_m1 : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    idx = s_addr[ib-1:lw];
    line = mem[idx];
    is_wr = (s_type == 3'd1) | (s_type == 3'd2);
    off = int'(s_addr[lw-1:0]);
    n = int'(s_len);
    // len==0 is a whole aligned line; partial writes are clipped at the line end
    doff = (s_len == '0) ? 0 : off;
    wline = line;
    for (int i = 0; i < nb; i++)
      wline[8*i +: 8] = ((s_len == '0) || (i >= off && i < off + n)) ? s_data[8*((i - doff) & (nb - 1)) +: 8] : line[8*i +: 8];
    resp_d = enter ? {s_type, s_opaque, {lw{1'b0}}, (s_type == 3'd0) ? line : {clw{1'b0}}} : resp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      resp_q <= resp_d;
    end
    type_q <= type_d;
    opaque_q <= opaque_d;
    addr_q <= addr_d;
    len_q <= len_d;
    data_q <= data_d;
  end
  always_ff @(posedge clk)
    if (enter & is_wr) mem[idx] <= wline;
endmodule

// File: doc/plab3_mem_line_responder.md
Name: plab3_mem_line_responder

Overview:
- Cacheline-granularity memory responder: the memory-side end of the L1 cache's refill/evict interface.
- Accepts VC mem request messages with 128-bit data on a val/rdy port and services them from an internal byte-addressed store after a fixed programmable latency.
- Returns VC mem response messages on a val/rdy port.
- Used as backing memory under the blocking L1 cache in unit and system tests; carries a single security domain like the cache datapath.

Parameters:
- p_mem_nbytes, 4096, store size in bytes; power of two, multiple of 16.
- p_opaque_nbits, 8, opaque field width (o).
- p_latency, 2, extra cycles between request accept and response valid; 0..15.
- abw, 32, address width.
- clw, 128, cacheline/data width.

Ports:
- clk, input, 1, clock, {L}.
- reset, input, 1, synchronous active-high reset, {L}.
- domain, input, 1, security domain of all other ports, {L}.
- memreq_val, input, 1, request valid.
- memreq_rdy, output, 1, request ready.
- memreq_msg, input, VC_MEM_REQ_MSG_NBITS(o,abw,clw), fields {type[2:0], opaque, addr, len, data}.
- memresp_val, output, 1, response valid.
- memresp_rdy, input, 1, response ready.
- memresp_msg, output, VC_MEM_RESP_MSG_NBITS(o,clw), fields {type, opaque, len, data}.

Behaviour:
- All message ports and internal state are labelled {Domain domain}.
- Reset is synchronous and active-high.
  - In the cycle after reset is sampled high: FSM=IDLE, memreq_rdy=0 while reset is high, memresp_val=0, memresp_msg=0, latency counter=0.
  - Store contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: memreq_rdy=1 and memresp_val=0. When memreq_val & memreq_rdy, latch type, opaque, addr, len and data. Go to RESP if p_latency==0, else go to WAIT with counter=p_latency-1.
  - WAIT: memreq_rdy=0. Decrement counter each cycle; when counter==0, go to RESP next cycle.
  - RESP: memresp_val=1 and memreq_rdy=0. Hold memresp_msg stable until memresp_rdy. On the handshake, return to IDLE; memreq_rdy=1 in the following cycle.
- Timing: a request accepted at edge T produces memresp_val at cycle T+1+p_latency. With memresp_rdy held high, the next request is accepted at the earliest 2+p_latency cycles after T.
- Line index = addr[log2(p_mem_nbytes)-1:4], so addresses wrap modulo p_mem_nbytes. Read data always comes from the line-aligned address; addr[3:0] is ignored for reads.
- Type decoding:
  - Type 0 (read): resp data = the full 16-byte line, sampled when entering RESP.
  - Type 1 (write) and type 2 (write-init):
    - Store is updated on the cycle the FSM enters RESP.
    - len==0 writes all 16 bytes.
    - len==n writes data bytes [n-1:0] to line bytes addr[3:0]..addr[3:0]+n-1; bytes beyond line byte 15 are dropped (no wrap into the next line).
    - Resp data = 0.
  - Types 3..7: no store update, resp data = 0.
- Response fields: type echoed, opaque echoed, len=0.
- Only one request is in flight at a time; no request queueing.
- memreq_val during WAIT/RESP is ignored; the sender holds it.
- A read immediately following a write to the same line returns the new data.
- Reset asserted mid-transaction (WAIT or RESP): the in-flight transaction is discarded and no response is issued. A write whose store update already happened remains in the store.
- memresp_rdy high while not in RESP has no effect.

Test Plan:
- Reset, then write type=1 addr=0x0000_0040 len=0 data=0x0123456789ABCDEF_FEDCBA9876543210 opaque=0x05; then read addr=0x40 opaque=0x06 -> write resp type=1 opaque=0x05 data=0; read resp type=0 opaque=0x06 data=0x0123456789ABCDEF_FEDCBA9876543210.
- p_latency=2, memresp_rdy=1, request accepted at cycle 10 -> memresp_val=1 first at cycle 13; memreq_rdy=0 in cycles 11-13 and 1 in cycle 14.
- Backpressure: memresp_rdy=0 for 5 cycles during RESP -> memresp_val and memresp_msg stable throughout, memreq_rdy=0; handshake on rdy rise.
- Partial write: line 0x80 preset to all 0x00; write addr=0x8E len=4 data low bytes 0xDDCCBBAA -> read 0x80 returns byte14=0xAA, byte15=0xBB, all other bytes 0x00.
- Wrap: p_mem_nbytes=4096; write addr=0x1010 data=X, then read addr=0x0010 -> returns X.
- Reset asserted while in WAIT -> no memresp_val; memreq_rdy=1 in the cycle after reset deasserts; next read is serviced normally.
